// File: rtl/mem_bus_bridge.sv
// Data-bus bridge: turns core byte/halfword/word requests into one word-addressed,
// byte-enabled memory transaction with req/ack handshake and an ack watchdog.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] db_addr,
    input  logic [1:0]  db_accessType,
    input  logic [1:0]  db_memLen,
    input  logic [31:0] db_dataOut,
    output logic [31:0] db_dataIn,
    output logic        db_ready,
    output logic [1:0]  db_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [29:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        db_dataIn_q, db_dataIn_d;
    logic [1:0]         db_fault_q, db_fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         len_q, len_d;

    logic accept;
    logic legal;
    logic timeout_hit;

    function automatic logic is_legal(input logic [1:0] len, input logic [1:0] off);
        case (len)
            2'd0:    return 1'b1;
            2'd1:    return ~off[0];
            2'd2:    return (off == 2'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
        case (len)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] len, input logic [31:0] d);
        case (len)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Move the addressed lane(s) down to bit 0 and clear everything above the access length.
    function automatic logic [31:0] steer_read(input logic [1:0] len, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (len)
            2'd0:    return {24'd0, shifted[7:0]};
            2'd1:    return {16'd0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    assign accept      = (state_q != BUSY) && (db_accessType != 2'd0);
    assign legal       = is_legal(db_memLen, db_addr[1:0]);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            db_dataIn_q <= '0;
            db_fault_q  <= '0;
            cnt_q       <= '0;
            off_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            db_dataIn_q <= db_dataIn_d;
            db_fault_q  <= db_fault_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            len_q       <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = legal ? BUSY : DONE;
                else        state_d = IDLE;
            end
            BUSY: begin
                if (mem_ack || timeout_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        db_dataIn_d = db_dataIn_q;
        db_fault_d  = db_fault_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        len_d       = len_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    off_d = db_addr[1:0];
                    len_d = db_memLen;
                    if (legal) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (db_accessType == 2'd2);
                        mem_addr_d  = db_addr[31:2];
                        mem_be_d    = byte_en(db_memLen, db_addr[1:0]);
                        mem_wdata_d = lane_data(db_memLen, db_dataOut);
                        cnt_d       = '0;
                    end else begin
                        db_fault_d  = 2'd1;
                        db_dataIn_d = '0;
                    end
                end
            end
            BUSY: begin
                // An ack in the final watchdog cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    db_fault_d  = 2'd0;
                    db_dataIn_d = mem_we_q ? 32'd0 : steer_read(len_q, off_q, mem_rdata);
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    db_fault_d  = 2'd2;
                    db_dataIn_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign db_ready  = (state_q == DONE);
    assign db_dataIn = db_dataIn_q;
    assign db_fault  = db_fault_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
endmodule
